pipe_latch_skid: RTL and testbench
==================================

# pipe_latch_skid

Parametrised decode→execute pipeline register with valid/ready handshake, optional skid entry, synchronous flush (bubble insertion) and a saturating stall counter. It carries register values, register indices, sign-extended immediate, PC+4 and a control bundle from the decode stage into the execute stage. It supersedes the plain always-load decode latch: it can hold under back-pressure without losing an instruction, and it presents an all-zero bubble whenever it is empty.

## Interface
- DATA_W, 32, width of reg1, reg2, signimm, pcplus4 fields
- REGIDX_W, 5, width of rs, rt, rd fields
- CTRL_W, 8, width of opaque control bundle
- SKID, 1, 1 = two-entry skid stage with registered in_ready; 0 = single register with combinational ready
- STALL_W, 16, width of stall counter

- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of all held entries
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage can accept this cycle
- reg1_dec, reg2_dec, signimm_dec, pcplus4_dec  in  DATA_W each  decode payload
- rs_dec, rt_dec, rd_dec  in  REGIDX_W each  decode register indices
- ctrl_dec  in  CTRL_W  decode control bundle
- out_valid  out  1  execute-side payload valid
- out_ready  in  1  execute consumes this cycle
- reg1_exe, reg2_exe, signimm_exe, pcplus4_exe, rs_exe, rt_exe, rd_exe, ctrl_exe  out  matching widths  head-entry payload
- stall_cnt  out  STALL_W  cycles with out_valid=1 and out_ready=0

## Operation
- acc = in_valid & in_ready; deq = out_valid & out_ready.
- Head entry (main) drives all *_exe outputs; skid entry is internal.
- Empty head: all *_exe fields are 0 (rd=0 bubble, no false forwarding match on rs/rt/rd).
- SKID=1 states: EMPTY, ONE (main valid), FULL (main+skid valid). in_ready = !skid_valid (flop output only).
  - EMPTY: acc → ONE, main←in.
  - ONE: acc&deq → ONE, main←in; acc&!deq → FULL, skid←in; !acc&deq → EMPTY, main←0; else hold.
  - FULL: deq → ONE, main←skid, skid←0; else hold. No accept possible.
- SKID=0: single entry; in_ready = !out_valid | out_ready (combinational). acc → main←in; !acc&deq → main←0.
- Ordering strictly FIFO; no entry is dropped or duplicated except by flush.
- flush (priority over everything): next state EMPTY, main and skid zeroed, payload presented with in_valid that cycle is dropped even if in_ready=1. deq in the same cycle is still a valid consume by execute.
- stall_cnt: +1 each cycle with out_valid & !out_ready; saturates at 2^STALL_W−1; cleared only by reset_n.
- Widths are pass-through; no arithmetic on payload.

## Timing
- Reset (reset_n=0, asynchronous): out_valid=0, all *_exe=0, stall_cnt=0, state EMPTY, in_ready=1 (both modes while held in reset and after release).
- Latency: accepted at edge N → visible on *_exe with out_valid=1 after edge N, i.e. during cycle N+1.
- Throughput: 1 instruction/cycle with out_ready held 1, both modes.
- SKID=1: out_ready falling with in_valid=1 absorbs exactly one extra instruction into skid; in_ready drops the next cycle. in_ready returns 1 the cycle after the FULL→ONE transition.
- SKID=1 has no combinational path out_ready→in_ready; SKID=0 has exactly that path.
- flush at edge N: out_valid=0 and all fields 0 during cycle N+1; a new accept is possible at edge N+1.
- reset_n asserted mid-transfer: entries discarded immediately, outputs zero asynchronously.

## Test plan
- Reset: hold reset_n=0 with in_valid=1, pcplus4_dec=0x104 → out_valid=0, all *_exe=0, in_ready=1, stall_cnt=0; release → first accept appears next cycle with pcplus4_exe=0x104.
- Streaming: SKID=1, out_ready=1, push pcplus4 0x4,0x8,0xC on consecutive cycles → identical sequence on pcplus4_exe one cycle later, out_valid continuous, in_ready never low.
- Back-pressure: SKID=1, push 0x10,0x14,0x18 while out_ready=0 from the second cycle → 0x10 held at head, 0x14 in skid, in_ready=0, 0x18 not accepted; raise out_ready → 0x10, 0x14, 0x18 in order, stall_cnt equals the low cycles.
- Flush: state FULL (rd 3 at head, rd 7 in skid), pulse flush with in_valid=1, rd_dec=9 → next cycle out_valid=0, rd_exe=0, rs_exe=0; rd 9 never emerges.
- SKID=0: out_valid=1, out_ready=0 → in_ready=0 same cycle; out_ready=1 with in_valid=1 → head replaced next cycle, no bubble.
- Saturation: STALL_W=4, hold out_valid=1, out_ready=0 for 20 cycles → stall_cnt stops at 15.

Source files
------------

// File: rtl/pipe_latch_skid.sv
// rtl/pipe_latch_skid.sv - decode->execute pipeline register with handshake, optional skid entry, flush and stall counter
//
// Purpose: carries decode payload (register values, register indices, sign-extended
// immediate, PC+4, control bundle) into the execute stage. Holds under back-pressure
// without losing an instruction and presents an all-zero bubble whenever empty.
//
// Ports:
//   clk, reset_n             clock (rising edge), asynchronous active-low reset
//   flush                    synchronous clear of all held entries (highest priority)
//   in_valid / in_ready      decode-side handshake
//   *_dec                    decode payload fields
//   out_valid / out_ready    execute-side handshake
//   *_exe                    head-entry payload (all zero when empty)
//   stall_cnt                saturating count of cycles with out_valid=1, out_ready=0

module pipe_latch_skid #(
  parameter int DATA_W   = 32,
  parameter int REGIDX_W = 5,
  parameter int CTRL_W   = 8,
  parameter int SKID     = 1,
  parameter int STALL_W  = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   reg1_dec,
  input  logic [DATA_W-1:0]   reg2_dec,
  input  logic [DATA_W-1:0]   signimm_dec,
  input  logic [DATA_W-1:0]   pcplus4_dec,
  input  logic [REGIDX_W-1:0] rs_dec,
  input  logic [REGIDX_W-1:0] rt_dec,
  input  logic [REGIDX_W-1:0] rd_dec,
  input  logic [CTRL_W-1:0]   ctrl_dec,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   reg1_exe,
  output logic [DATA_W-1:0]   reg2_exe,
  output logic [DATA_W-1:0]   signimm_exe,
  output logic [DATA_W-1:0]   pcplus4_exe,
  output logic [REGIDX_W-1:0] rs_exe,
  output logic [REGIDX_W-1:0] rt_exe,
  output logic [REGIDX_W-1:0] rd_exe,
  output logic [CTRL_W-1:0]   ctrl_exe,
  output logic [STALL_W-1:0]  stall_cnt
);

  localparam int PW = 4 * DATA_W + 3 * REGIDX_W + CTRL_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    main_q, main_d;
  logic [PW-1:0]    skid_q, skid_d;
  logic [PW-1:0]    in_pay;
  logic             in_ready_q;
  logic [STALL_W-1:0] stall_q;
  logic             acc, deq;

  assign in_pay = {reg1_dec, reg2_dec, signimm_dec, pcplus4_dec,
                   rs_dec, rt_dec, rd_dec, ctrl_dec};

  assign out_valid = (state_q != ST_EMPTY);

  // Skid mode: ready is a flop (no out_ready->in_ready path).
  // Single-register mode: ready is combinational on out_ready.
  assign in_ready = (SKID != 0) ? in_ready_q
                                : ((state_q == ST_EMPTY) || out_ready);

  assign acc = in_valid & in_ready;
  assign deq = out_valid & out_ready;

  // main_q is kept zero whenever the stage is empty, so it drives the outputs directly.
  assign {reg1_exe, reg2_exe, signimm_exe, pcplus4_exe,
          rs_exe, rt_exe, rd_exe, ctrl_exe} = main_q;

  assign stall_cnt = stall_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d = ST_ONE;
            main_d  = in_pay;
          end
        end
        ST_ONE: begin
          if (acc && deq) begin
            main_d = in_pay;
          end else if (acc && (SKID != 0)) begin
            // Head is stalled; park the new instruction behind it.
            state_d = ST_FULL;
            skid_d  = in_pay;
          end else if (deq) begin
            state_d = ST_EMPTY;
            main_d  = '0;
          end
        end
        ST_FULL: begin
          if (deq) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != ST_FULL);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != {STALL_W{1'b1}})) begin
      stall_q <= stall_q + STALL_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_latch_skid.sv
// tb/tb_pipe_latch_skid.sv - self-checking bench for pipe_latch_skid (skid and single-register modes)

module tb_pipe_latch_skid;

  typedef logic [150:0] pay_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, flush, in_valid, out_ready;
  pay_t din;

  logic [31:0] reg1_dec, reg2_dec, signimm_dec, pcplus4_dec;
  logic [4:0]  rs_dec, rt_dec, rd_dec;
  logic [7:0]  ctrl_dec;
  assign {reg1_dec, reg2_dec, signimm_dec, pcplus4_dec, rs_dec, rt_dec, rd_dec, ctrl_dec} = din;

  logic        out_valid_s, in_ready_s;
  logic [31:0] reg1_exe_s, reg2_exe_s, signimm_exe_s, pcplus4_exe_s;
  logic [4:0]  rs_exe_s, rt_exe_s, rd_exe_s;
  logic [7:0]  ctrl_exe_s;
  logic [3:0]  stall_s;
  pay_t        dout_s;
  assign dout_s = {reg1_exe_s, reg2_exe_s, signimm_exe_s, pcplus4_exe_s,
                   rs_exe_s, rt_exe_s, rd_exe_s, ctrl_exe_s};

  logic        out_valid_n, in_ready_n;
  logic [31:0] reg1_exe_n, reg2_exe_n, signimm_exe_n, pcplus4_exe_n;
  logic [4:0]  rs_exe_n, rt_exe_n, rd_exe_n;
  logic [7:0]  ctrl_exe_n;
  logic [15:0] stall_n;
  pay_t        dout_n;
  assign dout_n = {reg1_exe_n, reg2_exe_n, signimm_exe_n, pcplus4_exe_n,
                   rs_exe_n, rt_exe_n, rd_exe_n, ctrl_exe_n};

  pipe_latch_skid #(.DATA_W(32), .REGIDX_W(5), .CTRL_W(8), .SKID(1), .STALL_W(4)) u_s (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_s),
    .reg1_dec(reg1_dec), .reg2_dec(reg2_dec), .signimm_dec(signimm_dec), .pcplus4_dec(pcplus4_dec),
    .rs_dec(rs_dec), .rt_dec(rt_dec), .rd_dec(rd_dec), .ctrl_dec(ctrl_dec),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .reg1_exe(reg1_exe_s), .reg2_exe(reg2_exe_s), .signimm_exe(signimm_exe_s), .pcplus4_exe(pcplus4_exe_s),
    .rs_exe(rs_exe_s), .rt_exe(rt_exe_s), .rd_exe(rd_exe_s), .ctrl_exe(ctrl_exe_s),
    .stall_cnt(stall_s)
  );

  pipe_latch_skid #(.DATA_W(32), .REGIDX_W(5), .CTRL_W(8), .SKID(0), .STALL_W(16)) u_n (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_n),
    .reg1_dec(reg1_dec), .reg2_dec(reg2_dec), .signimm_dec(signimm_dec), .pcplus4_dec(pcplus4_dec),
    .rs_dec(rs_dec), .rt_dec(rt_dec), .rd_dec(rd_dec), .ctrl_dec(ctrl_dec),
    .out_valid(out_valid_n), .out_ready(out_ready),
    .reg1_exe(reg1_exe_n), .reg2_exe(reg2_exe_n), .signimm_exe(signimm_exe_n), .pcplus4_exe(pcplus4_exe_n),
    .rs_exe(rs_exe_n), .rt_exe(rt_exe_n), .rd_exe(rd_exe_n), .ctrl_exe(ctrl_exe_n),
    .stall_cnt(stall_n)
  );

  int passed = 0;
  int total  = 0;

  // Reference model: each stage is a FIFO of bounded depth plus a saturating counter.
  pay_t qs[$];
  pay_t qn[$];
  int   cs, cn;

  function automatic logic m_valid_s(); return qs.size() != 0; endfunction
  function automatic logic m_valid_n(); return qn.size() != 0; endfunction
  function automatic pay_t m_head_s(); return (qs.size() != 0) ? qs[0] : '0; endfunction
  function automatic pay_t m_head_n(); return (qn.size() != 0) ? qn[0] : '0; endfunction
  function automatic logic m_ready_s(); return qs.size() < 2; endfunction
  function automatic logic m_ready_n(); return (qn.size() == 0) || out_ready; endfunction

  function automatic pay_t mk(input logic [31:0] pc, input logic [4:0] rd);
    pay_t p;
    p[150:119] = $urandom();
    p[118:87]  = $urandom();
    p[86:55]   = $urandom();
    p[22:0]    = 23'($urandom());
    p[54:23]   = pc;
    p[12:8]    = rd;
    return p;
  endfunction

  // Advance the model by one clock using the inputs currently driven, then
  // move to the next falling edge where new inputs are applied.
  task automatic tick();
    logic acc_s, acc_n, deq_s, deq_n;
    acc_s = in_valid && m_ready_s();
    acc_n = in_valid && m_ready_n();
    deq_s = m_valid_s() && out_ready;
    deq_n = m_valid_n() && out_ready;
    if (m_valid_s() && !out_ready && cs < 15) cs++;
    if (m_valid_n() && !out_ready && cn < 65535) cn++;
    if (flush) begin
      qs.delete();
      qn.delete();
    end else begin
      if (deq_s) void'(qs.pop_front());
      if (acc_s) qs.push_back(din);
      if (deq_n) void'(qn.pop_front());
      if (acc_n) qn.push_back(din);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din = '0;
    qs.delete(); qn.delete(); cs = 0; cn = 0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; din = mk(32'h104, 5'd1);
    qs.delete(); qn.delete(); cs = 0; cn = 0;
    #1;
    total++; if (out_valid_s !== 1'b0) $display("FAIL reset_valid_s: got %0b want 0", out_valid_s); else passed++;
    total++; if (dout_s !== '0) $display("FAIL reset_payload_s: got %h want 0", dout_s); else passed++;
    total++; if (in_ready_s !== 1'b1) $display("FAIL reset_ready_s: got %0b want 1", in_ready_s); else passed++;
    total++; if (stall_s !== 4'd0) $display("FAIL reset_stall_s: got %0d want 0", stall_s); else passed++;
    total++; if (out_valid_n !== 1'b0) $display("FAIL reset_valid_n: got %0b want 0", out_valid_n); else passed++;
    total++; if (dout_n !== '0) $display("FAIL reset_payload_n: got %h want 0", dout_n); else passed++;
    total++; if (in_ready_n !== 1'b1) $display("FAIL reset_ready_n: got %0b want 1", in_ready_n); else passed++;
    total++; if (stall_n !== 16'd0) $display("FAIL reset_stall_n: got %0d want 0", stall_n); else passed++;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    total++; if (in_ready_s !== 1'b1) $display("FAIL release_ready_s: got %0b want 1", in_ready_s); else passed++;
    tick();
    in_valid = 1'b0;
    #1;
    total++; if (out_valid_s !== 1'b1 || pcplus4_exe_s !== 32'h104)
      $display("FAIL first_accept_s: got v=%0b pc=%h want v=1 pc=104", out_valid_s, pcplus4_exe_s); else passed++;
    total++; if (out_valid_n !== 1'b1 || pcplus4_exe_n !== 32'h104)
      $display("FAIL first_accept_n: got v=%0b pc=%h want v=1 pc=104", out_valid_n, pcplus4_exe_n); else passed++;
    tick();
  endtask

  task automatic test_streaming();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      din = mk(32'(4 * (i + 1)), 5'($urandom()));
      #1;
      total++; if (in_ready_s !== 1'b1) $display("FAIL stream_ready_s[%0d]: got %0b want 1", i, in_ready_s); else passed++;
      if (i > 0) begin
        total++; if (out_valid_s !== 1'b1 || pcplus4_exe_s !== 32'(4 * i))
          $display("FAIL stream_out_s[%0d]: got v=%0b pc=%h want v=1 pc=%h", i, out_valid_s, pcplus4_exe_s, 4 * i); else passed++;
        total++; if (out_valid_n !== 1'b1 || pcplus4_exe_n !== 32'(4 * i))
          $display("FAIL stream_out_n[%0d]: got v=%0b pc=%h want v=1 pc=%h", i, out_valid_n, pcplus4_exe_n, 4 * i); else passed++;
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    total++; if (out_valid_s !== 1'b1 || pcplus4_exe_s !== 32'hC)
      $display("FAIL stream_last_s: got v=%0b pc=%h want v=1 pc=c", out_valid_s, pcplus4_exe_s); else passed++;
    tick();
    total++; if (out_valid_s !== 1'b0) $display("FAIL stream_drain_s: got %0b want 0", out_valid_s); else passed++;
  endtask

  task automatic test_back_pressure();
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1; din = mk(32'h10, 5'd1);
    tick();
    out_ready = 1'b0; din = mk(32'h14, 5'd2);
    #1;
    total++; if (in_ready_s !== 1'b1) $display("FAIL bp_ready1_s: got %0b want 1", in_ready_s); else passed++;
    tick();
    din = mk(32'h18, 5'd3);
    #1;
    total++; if (in_ready_s !== 1'b0) $display("FAIL bp_ready2_s: got %0b want 0", in_ready_s); else passed++;
    total++; if (pcplus4_exe_s !== 32'h10) $display("FAIL bp_head2_s: got %h want 10", pcplus4_exe_s); else passed++;
    tick();
    #1;
    total++; if (in_ready_s !== 1'b0) $display("FAIL bp_ready3_s: got %0b want 0", in_ready_s); else passed++;
    tick();
    out_ready = 1'b1;
    #1;
    total++; if (pcplus4_exe_s !== 32'h10) $display("FAIL bp_out0_s: got %h want 10", pcplus4_exe_s); else passed++;
    total++; if (stall_s !== 4'd3) $display("FAIL bp_stall_s: got %0d want 3", stall_s); else passed++;
    total++; if (in_ready_s !== 1'b0) $display("FAIL bp_ready4_s: got %0b want 0", in_ready_s); else passed++;
    tick();
    #1;
    total++; if (pcplus4_exe_s !== 32'h14) $display("FAIL bp_out1_s: got %h want 14", pcplus4_exe_s); else passed++;
    total++; if (in_ready_s !== 1'b1) $display("FAIL bp_ready5_s: got %0b want 1", in_ready_s); else passed++;
    tick();
    in_valid = 1'b0;
    #1;
    total++; if (out_valid_s !== 1'b1 || pcplus4_exe_s !== 32'h18)
      $display("FAIL bp_out2_s: got v=%0b pc=%h want v=1 pc=18", out_valid_s, pcplus4_exe_s); else passed++;
    tick();
    total++; if (out_valid_s !== 1'b0) $display("FAIL bp_drain_s: got %0b want 0", out_valid_s); else passed++;
    total++; if (stall_s !== 4'd3) $display("FAIL bp_stall_end_s: got %0d want 3", stall_s); else passed++;
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1'b1; out_ready = 1'b0; din = mk(32'h40, 5'd3);
    tick();
    din = mk(32'h44, 5'd7);
    tick();
    flush = 1'b1; din = mk(32'h48, 5'd9);
    #1;
    total++; if (rd_exe_s !== 5'd3 || in_ready_s !== 1'b0)
      $display("FAIL flush_pre_s: got rd=%0d rdy=%0b want rd=3 rdy=0", rd_exe_s, in_ready_s); else passed++;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    total++; if (out_valid_s !== 1'b0 || rd_exe_s !== 5'd0 || rs_exe_s !== 5'd0)
      $display("FAIL flush_bubble_s: got v=%0b rd=%0d rs=%0d want 0 0 0", out_valid_s, rd_exe_s, rs_exe_s); else passed++;
    total++; if (dout_s !== '0) $display("FAIL flush_zero_s: got %h want 0", dout_s); else passed++;
    total++; if (out_valid_n !== 1'b0 || dout_n !== '0)
      $display("FAIL flush_bubble_n: got v=%0b d=%h want 0", out_valid_n, dout_n); else passed++;
    total++; if (in_ready_s !== 1'b1) $display("FAIL flush_ready_s: got %0b want 1", in_ready_s); else passed++;
    in_valid = 1'b1; din = mk(32'h4C, 5'd5);
    tick();
    in_valid = 1'b0;
    #1;
    total++; if (out_valid_s !== 1'b1 || rd_exe_s !== 5'd5)
      $display("FAIL flush_reaccept_s: got v=%0b rd=%0d want v=1 rd=5", out_valid_s, rd_exe_s); else passed++;
    tick();
    total++; if (out_valid_s !== 1'b0 || rd_exe_s === 5'd9)
      $display("FAIL flush_no_rd9_s: got v=%0b rd=%0d want v=0 rd!=9", out_valid_s, rd_exe_s); else passed++;
  endtask

  task automatic test_noskid();
    do_reset();
    in_valid = 1'b1; out_ready = 1'b0; din = mk(32'h20, 5'd4);
    tick();
    in_valid = 1'b0;
    #1;
    total++; if (out_valid_n !== 1'b1 || in_ready_n !== 1'b0)
      $display("FAIL noskid_stall: got v=%0b rdy=%0b want v=1 rdy=0", out_valid_n, in_ready_n); else passed++;
    out_ready = 1'b1; in_valid = 1'b1; din = mk(32'h24, 5'd6);
    #1;
    total++; if (in_ready_n !== 1'b1) $display("FAIL noskid_comb_ready: got %0b want 1", in_ready_n); else passed++;
    tick();
    in_valid = 1'b0;
    #1;
    total++; if (out_valid_n !== 1'b1 || pcplus4_exe_n !== 32'h24)
      $display("FAIL noskid_replace: got v=%0b pc=%h want v=1 pc=24", out_valid_n, pcplus4_exe_n); else passed++;
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    in_valid = 1'b1; out_ready = 1'b0; din = mk(32'h80, 5'd2);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    total++; if (stall_s !== 4'd15) $display("FAIL sat_stall_s: got %0d want 15", stall_s); else passed++;
    total++; if (stall_n !== 16'd20) $display("FAIL sat_stall_n: got %0d want 20", stall_n); else passed++;
    tick();
    total++; if (stall_s !== 4'd15) $display("FAIL sat_hold_s: got %0d want 15", stall_s); else passed++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      din       = mk($urandom(), 5'($urandom()));
      #1;
      total++; if (out_valid_s !== m_valid_s()) $display("FAIL rnd_valid_s[%0d]: got %0b want %0b", i, out_valid_s, m_valid_s()); else passed++;
      total++; if (dout_s !== m_head_s()) $display("FAIL rnd_data_s[%0d]: got %h want %h", i, dout_s, m_head_s()); else passed++;
      total++; if (in_ready_s !== m_ready_s()) $display("FAIL rnd_ready_s[%0d]: got %0b want %0b", i, in_ready_s, m_ready_s()); else passed++;
      total++; if (stall_s !== 4'(cs)) $display("FAIL rnd_stall_s[%0d]: got %0d want %0d", i, stall_s, cs); else passed++;
      total++; if (out_valid_n !== m_valid_n()) $display("FAIL rnd_valid_n[%0d]: got %0b want %0b", i, out_valid_n, m_valid_n()); else passed++;
      total++; if (dout_n !== m_head_n()) $display("FAIL rnd_data_n[%0d]: got %h want %h", i, dout_n, m_head_n()); else passed++;
      total++; if (in_ready_n !== m_ready_n()) $display("FAIL rnd_ready_n[%0d]: got %0b want %0b", i, in_ready_n, m_ready_n()); else passed++;
      total++; if (stall_n !== 16'(cn)) $display("FAIL rnd_stall_n[%0d]: got %0d want %0d", i, stall_n, cn); else passed++;
      tick();
    end
    flush = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    in_valid = 1'b1; out_ready = 1'b0; din = mk(32'hA0, 5'd8);
    tick();
    din = mk(32'hA4, 5'd9);
    tick();
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    qs.delete(); qn.delete(); cs = 0; cn = 0;
    #1;
    total++; if (out_valid_s !== 1'b0 || dout_s !== '0 || stall_s !== 4'd0)
      $display("FAIL async_reset_s: got v=%0b d=%h st=%0d want 0", out_valid_s, dout_s, stall_s); else passed++;
    total++; if (out_valid_n !== 1'b0 || dout_n !== '0 || stall_n !== 16'd0)
      $display("FAIL async_reset_n: got v=%0b d=%h st=%0d want 0", out_valid_n, dout_n, stall_n); else passed++;
    total++; if (in_ready_s !== 1'b1) $display("FAIL async_reset_ready_s: got %0b want 1", in_ready_s); else passed++;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din = '0;
    cs = 0; cn = 0;
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_noskid();
    test_saturation();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
